// File: rtl/alu_pkg.sv
// Shared encodings and defaults for the sequential ALU shifter.
// The op encodings match the ALU opcode field that drives in_op.
package alu_pkg;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_SHW   = 5;

   typedef enum logic [1:0] {
      OP_SLL = 2'b00,
      OP_SRL = 2'b01,
      OP_SRA = 2'b10,
      OP_ROR = 2'b11
   } op_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_DONE  = 2'b10
   } state_t;

endpackage

// File: rtl/alu_shift_step.sv
// Purely combinational one-bit shift/rotate step.
// carry_out is the bit that leaves the word on this step.
module alu_shift_step
   import alu_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic [WIDTH-1:0] data,
   input  logic [1:0]       op,
   output logic [WIDTH-1:0] next_data,
   output logic             carry_out
);

   always_comb begin
      next_data = data;
      carry_out = 1'b0;
      case (op_t'(op))
         OP_SLL: begin
            carry_out = data[WIDTH-1];
            next_data = {data[WIDTH-2:0], 1'b0};
         end
         OP_SRL: begin
            carry_out = data[0];
            next_data = {1'b0, data[WIDTH-1:1]};
         end
         OP_SRA: begin
            carry_out = data[0];
            next_data = {data[WIDTH-1], data[WIDTH-1:1]};
         end
         OP_ROR: begin
            carry_out = data[0];
            next_data = {data[0], data[WIDTH-1:1]};
         end
         default: begin
            next_data = data;
            carry_out = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/alu_seq_shifter.sv
// Multi-cycle shifter: one bit position per clock, valid/ready on both sides.
// Handshakes: a transfer happens on an edge where valid and ready are both high.
module alu_seq_shifter
   import alu_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int SHW   = DEF_SHW
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [SHW-1:0]   in_amount,
   input  logic [1:0]       in_op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_carry,
   output logic             out_zero
);

   state_t           state_q;
   state_t           state_d;
   logic [WIDTH-1:0] data_q;
   logic [SHW-1:0]   count_q;
   logic [1:0]       op_q;
   logic             carry_q;
   logic [WIDTH-1:0] step_data;
   logic             step_carry;
   logic             accept;

   assign accept = in_valid && (state_q == ST_IDLE);

   alu_shift_step #(.WIDTH(WIDTH)) u_step (
      .data      (data_q),
      .op        (op_q),
      .next_data (step_data),
      .carry_out (step_carry)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (in_valid) state_d = (in_amount != '0) ? ST_SHIFT : ST_DONE;
         ST_SHIFT: if (count_q == SHW'(1)) state_d = ST_DONE;
         ST_DONE:  if (out_ready) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Datapath: operands captured only at the accept edge, stepped only in SHIFT.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         data_q  <= '0;
         count_q <= '0;
         op_q    <= 2'b00;
         carry_q <= 1'b0;
      end else if (accept) begin
         data_q  <= in_data;
         count_q <= in_amount;
         op_q    <= in_op;
         carry_q <= 1'b0;
      end else if (state_q == ST_SHIFT) begin
         data_q  <= step_data;
         count_q <= count_q - SHW'(1);
         carry_q <= step_carry;
      end
   end

   always_comb begin
      in_ready  = (state_q == ST_IDLE);
      out_valid = (state_q == ST_DONE);
      out_data  = data_q;
      out_carry = carry_q;
      out_zero  = (data_q == '0);
   end

endmodule
